shift_rotate_unit: RTL and testbench
====================================

# shift_rotate_unit

Pipelined shift/rotate execution unit for the CPU datapath. It accepts an operation, a 32-bit operand and a shift count through a valid/ready handshake, and computes SHR, SHRA, SHL, ROR or ROL with a 5-stage log-shifter. It delivers the registered 32-bit result downstream to the ALU result/Z-register path. Throughput is one operation per cycle, latency is two cycles, and full backpressure is supported.

## Interface
- No parameters; data width fixed at 32, count width fixed at 5.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept request this cycle
- in_op  in  3  operation code (see Operation)
- in_a  in  32  operand to shift/rotate
- in_b  in  32  shift count; only in_b[4:0] used
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_result  out  32  shifted/rotated value
- out_illegal  out  1  result came from an undefined in_op
- out_zero  out  1  out_result == 0 (only with SHIFT_FLAGS_EN)
- out_neg  out  1  out_result[31] (only with SHIFT_FLAGS_EN)

## Operation
- Op codes: 3'b000 SHR (logical right), 3'b001 SHRA (arithmetic right, sign-fill from a[31]), 3'b010 SHL (zero-fill), 3'b011 ROR, 3'b100 ROL.
- Op codes 3'b101–3'b111 are illegal: result = in_a unchanged, out_illegal = 1.
- Count n = in_b[4:0] for every op; in_b[31:5] ignored (b = 32 behaves as n = 0).
- n = 0 returns in_a for all legal ops.
- Shifter: stages by 1, 2, 4, 8, 16 selected by n[0]..n[4]. Fill bits per op: rotate wraps, SHR/SHL zero, SHRA sign.
- Two register stages:
  - S1 captures {op, a, n}.
  - S2 captures the computed result and flags.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - in_ready = !s1_valid || s1_adv, where s1_adv = !s2_valid || out_ready. in_ready is combinationally dependent on out_ready.
  - out_valid is held, and out_result/flags are stable, until out_ready is sampled high.
- Simultaneous accept-in and drain-out on one edge is legal; no bubble is inserted.
- Results emerge strictly in request order; none dropped or duplicated.
- Reset:
  - rst high on any edge clears s1_valid and s2_valid, discarding in-flight operations.
  - Reset values: out_valid 0, out_result 0, out_illegal 0, out_zero 0, out_neg 0.
  - in_ready reads 1 the cycle after reset deasserts; in_ready is 1 while rst is high.

## Timing
- Request accepted at edge N → out_valid high after edge N+1 (result available in cycle N+1, transferable at edge N+2 at the earliest).
- Sustained back-to-back requests with out_ready = 1: one result per cycle.
- With out_ready = 0: the unit absorbs at most 2 requests (S1 + S2), then in_ready = 0.
- Combinational critical path: S1 register → 5 mux stages → S2 register. No path from in_* to out_*.
- Payload registers without a valid bit need no reset; only valid bits and output registers are reset.

## Configuration
- SHIFT_FLAGS_EN defined: out_zero and out_neg ports exist and are registered in S2 alongside out_result.
- SHIFT_FLAGS_EN undefined: both ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package/include `cpu_shift_pkg`: op-code constants (OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL), DATA_W = 32, CNT_W = 5.
- One combinational sub-module, `shift_core`: inputs (op, a, n), outputs (result, illegal). It implements all five ops as a single staged log-shifter with per-op fill selection.
- Top level holds the S1/S2 registers and the handshake logic.

## Test plan
- ROR a = 0x8000_0001, b = 1 → 0xC000_0000. ROL same a, b = 4 → 0x0000_0018. Each appears two cycles after acceptance.
- SHRA a = 0x8000_0000, b = 31 → 0xFFFF_FFFF. SHR same → 0x0000_0001. SHL a = 0x0000_0001, b = 0x21 → 0x0000_0002 (count masked to 1).
- Stream 8 mixed ops with out_ready = 1 → 8 results on 8 consecutive cycles, in order, in_ready constantly 1.
- Hold out_ready = 0, offer 3 requests → first two accepted, in_ready = 0 on the third. out_result is stable. Raise out_ready → all three drain in order.
- in_op = 3'b110, a = 0x1234_5678 → out_result 0x1234_5678, out_illegal = 1. With SHIFT_FLAGS_EN: a = 0, op ROR → out_zero = 1; a = 0x8000_0000, op SHL n = 0 → out_neg = 1.
- Assert rst with two operations in flight → after the edge, out_valid = 0 and out_result = 0. Neither discarded result ever appears, and in_ready = 1.

Source files
------------

// File: rtl/cpu_shift_pkg.sv
// Shared constants for the shift/rotate datapath: widths, op codes and a bit-reverse helper
// used to run left shifts through the single right-shifting log shifter.
package cpu_shift_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = x[DATA_W-1-i];
    return r;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 5-stage log shifter. Left ops are bit-reversed around the right shifter so
// every op shares one set of stages; only the fill bits differ per op.
module shift_core
  import cpu_shift_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [CNT_W-1:0]  i_n,
  output logic [DATA_W-1:0] o_result,
  output logic              o_illegal
);

  logic              w_left;
  logic              w_rot;
  logic              w_arith;
  logic              w_legal;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_fill;
  logic [DATA_W-1:0] w_shifted;

  always_comb begin
    w_left  = 1'b0;
    w_rot   = 1'b0;
    w_arith = 1'b0;
    w_legal = 1'b1;
    case (i_op)
      OP_SHR:  ;
      OP_SHRA: w_arith = 1'b1;
      OP_SHL:  w_left  = 1'b1;
      OP_ROR:  w_rot   = 1'b1;
      OP_ROL:  begin w_left = 1'b1; w_rot = 1'b1; end
      default: w_legal = 1'b0;
    endcase
  end

  // Stage k shifts right by 2**k; fill is the wrapped low bits, sign copies, or zeros.
  always_comb begin
    w_fill = '0;
    w_x    = w_left ? bit_rev(i_a) : i_a;
    for (int k = 0; k < CNT_W; k++) begin
      if (i_n[k]) begin
        if (w_rot)
          w_fill = w_x << (DATA_W - (1 << k));
        else if (w_arith && i_a[DATA_W-1])
          w_fill = ~({DATA_W{1'b1}} >> (1 << k));
        else
          w_fill = '0;
        w_x = (w_x >> (1 << k)) | w_fill;
      end
    end
    w_shifted = w_left ? bit_rev(w_x) : w_x;
  end

  assign o_result  = w_legal ? w_shifted : i_a;
  assign o_illegal = !w_legal;

endmodule

// File: rtl/shift_rotate_unit.sv
// Two-stage pipelined shift/rotate unit with valid/ready handshake and full backpressure.
// Define SHIFT_FLAGS_EN to add registered out_zero/out_neg result flags.
module shift_rotate_unit
  import cpu_shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_illegal
`ifdef SHIFT_FLAGS_EN
  ,
  output logic              out_zero,
  output logic              out_neg
`endif
);

  logic              r_s1_valid;
  logic [2:0]        r_s1_op;
  logic [DATA_W-1:0] r_s1_a;
  logic [CNT_W-1:0]  r_s1_n;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_result;
  logic              r_s2_illegal;

  logic              w_s1_adv;
  logic [DATA_W-1:0] w_result;
  logic              w_illegal;
  logic              w_unused_b;

  // Count bits above CNT_W are architecturally ignored.
  assign w_unused_b = ^in_b[DATA_W-1:CNT_W];

  assign w_s1_adv = !r_s2_valid || out_ready;
  assign in_ready = rst || !r_s1_valid || w_s1_adv;

  shift_core u_core (
    .i_op      (r_s1_op),
    .i_a       (r_s1_a),
    .i_n       (r_s1_n),
    .o_result  (w_result),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst && in_ready && in_valid) begin
      r_s1_op <= in_op;
      r_s1_a  <= in_a;
      r_s1_n  <= in_b[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_illegal <= 1'b0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result  <= w_result;
          r_s2_illegal <= w_illegal;
        end
      end
    end
  end

`ifdef SHIFT_FLAGS_EN
  logic r_s2_zero;
  logic r_s2_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_zero <= 1'b0;
      r_s2_neg  <= 1'b0;
    end else if (w_s1_adv && r_s1_valid) begin
      r_s2_zero <= (w_result == '0);
      r_s2_neg  <= w_result[DATA_W-1];
    end
  end

  assign out_zero = r_s2_zero;
  assign out_neg  = r_s2_neg;
`endif

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_illegal = r_s2_illegal;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed self-checking bench for shift_rotate_unit; inputs driven and outputs sampled
// on the falling edge. Flag checks are compiled in with SHIFT_FLAGS_EN.
module tb_shift_rotate_unit;
  import cpu_shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
`ifdef SHIFT_FLAGS_EN
  logic        out_zero;
  logic        out_neg;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_rotate_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal)
`ifdef SHIFT_FLAGS_EN
    ,
    .out_zero    (out_zero),
    .out_neg     (out_neg)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request through an otherwise idle pipe; result expected two falling edges later.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ill);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, out_result, exp_res);
    chk({tag, "_ill"}, out_illegal, exp_ill);
  endtask

  logic [2:0]  s_op  [8] = '{OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_SHL, OP_ROR, OP_SHRA};
  logic [31:0] s_a   [8] = '{32'hF000_000F, 32'hF000_000F, 32'hF000_000F, 32'hF000_000F,
                             32'hF000_000F, 32'h1234_5678, 32'h1234_5678, 32'h7FFF_FFFF};
  logic [31:0] s_b   [8] = '{4, 4, 4, 4, 4, 8, 16, 31};
  logic [31:0] s_exp [8] = '{32'h0F00_0000, 32'hFF00_0000, 32'h0000_00F0, 32'hFF00_0000,
                             32'h0000_00FF, 32'h3456_7800, 32'h5678_1234, 32'h0000_0000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", out_result, 0);
    chk("rst_ill", out_illegal, 0);
    chk("rst_rdy", in_ready, 1);
`ifdef SHIFT_FLAGS_EN
    chk("rst_zero", out_zero, 0);
    chk("rst_neg", out_neg, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1);

    run_one("ror1",  OP_ROR,  32'h8000_0001, 32'd1,  32'hC000_0000, 1'b0);
    run_one("rol4",  OP_ROL,  32'h8000_0001, 32'd4,  32'h0000_0018, 1'b0);
    run_one("sra31", OP_SHRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
    run_one("shr31", OP_SHR,  32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0);
    run_one("shl21", OP_SHL,  32'h0000_0001, 32'h21, 32'h0000_0002, 1'b0);
    run_one("ror32", OP_ROR,  32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0);
    run_one("ill6",  3'b110,  32'h1234_5678, 32'd3,  32'h1234_5678, 1'b1);
`ifdef SHIFT_FLAGS_EN
    chk("ill6_zero", out_zero, 0);
    run_one("zflag", OP_ROR,  32'h0000_0000, 32'd7,  32'h0000_0000, 1'b0);
    chk("zflag_zero", out_zero, 1);
    chk("zflag_neg", out_neg, 0);
    run_one("nflag", OP_SHL,  32'h8000_0000, 32'd0,  32'h8000_0000, 1'b0);
    chk("nflag_neg", out_neg, 1);
    chk("nflag_zero", out_zero, 0);
`endif

    // Back-to-back stream: result i observed at falling edge i+2.
    @(negedge clk);
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_op = s_op[c]; in_a = s_a[c]; in_b = s_b[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 8) chk($sformatf("strm_rdy%0d", c), in_ready, 1);
      chk($sformatf("strm_vld%0d", c), out_valid, (c >= 2 && c <= 9) ? 1 : 0);
      if (c >= 2 && c <= 9) chk($sformatf("strm_res%0d", c - 2), out_result, s_exp[c-2]);
      @(negedge clk);
    end

    // Backpressure: two requests absorbed, third stalls until out_ready rises.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ROL; in_a = 32'h8000_0001; in_b = 32'd1;
    #1 chk("bp_rdyA", in_ready, 1);
    @(negedge clk);
    in_op = OP_SHR; in_a = 32'h8000_0000; in_b = 32'd16;
    #1 chk("bp_rdyB", in_ready, 1);
    @(negedge clk);
    in_op = OP_SHL; in_a = 32'h0000_FFFF; in_b = 32'd16;
    #1 chk("bp_rdyC", in_ready, 0);
    chk("bp_vldA", out_valid, 1);
    chk("bp_resA", out_result, 32'h0000_0003);
    repeat (2) @(negedge clk);
    #1 chk("bp_stall_rdy", in_ready, 0);
    chk("bp_stable", out_result, 32'h0000_0003);
    out_ready = 1'b1;
    #1 chk("bp_rdy_comb", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_vldB", out_valid, 1);
    chk("bp_resB", out_result, 32'h0000_8000);
    @(negedge clk);
    chk("bp_vldC", out_valid, 1);
    chk("bp_resC", out_result, 32'hFFFF_0000);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_SHL; in_a = 32'h0000_0001; in_b = 32'd5;
    @(negedge clk);
    in_op = OP_ROR; in_a = 32'h0000_00FF; in_b = 32'd8;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("inflt_rdy", in_ready, 0);
    chk("inflt_res", out_result, 32'h0000_0020);
    rst = 1'b1;
    #1 chk("rsth_rdy", in_ready, 1);
    @(negedge clk);
    chk("rst2_vld", out_valid, 0);
    chk("rst2_res", out_result, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst2_gone%0d", c), out_valid, 0);
    end
    chk("rst2_rdy", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
